// File: rtl/bf_program_loader.sv
// Purpose: writable Brainfuck program store; encodes an ASCII source stream into 3-bit opcodes and checks brackets/capacity.
// Latency: accepted byte is written and counted at the same edge; status (done/err) is visible the cycle after the terminator.
// Backpressure: in_ready is high only in LOAD without a concurrent load_start; it stays low after DONE or ERR until the next load.
module bf_program_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int NEST_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [2:0]        code,
  output logic              rom_overrun,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [NEST_W-1:0] NEST_MAX = '1;

  localparam logic [2:0] OP_INC   = 3'b111;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_RIGHT = 3'b101;
  localparam logic [2:0] OP_LEFT  = 3'b100;
  localparam logic [2:0] OP_OPEN  = 3'b011;
  localparam logic [2:0] OP_CLOSE = 3'b010;
  localparam logic [2:0] OP_OUT   = 3'b001;
  localparam logic [2:0] OP_IN    = 3'b000;

  localparam logic [7:0] CH_TERM = 8'h21;

  state_t              state, state_d;
  logic [ADDR_W:0]     prog_len_d;
  logic [NEST_W-1:0]   depth, depth_d;
  logic [1:0]          err_d;

  logic                is_cmd;
  logic [2:0]          opcode;
  logic                accept;
  logic                wr_en;
  logic                rd_hit;

  // Program storage; deliberately unreset, stale entries are hidden by prog_len gating.
  logic [2:0]          mem [DEPTH];

  // Map an ASCII command byte to its opcode; anything else is flagged as a non-command.
  always_comb begin
    is_cmd = 1'b1;
    opcode = OP_INC;
    case (in_data)
      8'h2B:   opcode = OP_INC;
      8'h2D:   opcode = OP_DEC;
      8'h3E:   opcode = OP_RIGHT;
      8'h3C:   opcode = OP_LEFT;
      8'h5B:   opcode = OP_OPEN;
      8'h5D:   opcode = OP_CLOSE;
      8'h2E:   opcode = OP_OUT;
      8'h2C:   opcode = OP_IN;
      default: is_cmd = 1'b0;
    endcase
  end

  // A restart cycle never accepts data, so a byte offered with load_start is dropped.
  assign in_ready = (state == ST_LOAD) && !load_start;
  assign accept   = in_valid && in_ready;

  // Next-state, counters and error flags; all failing checks leave RAM and prog_len untouched.
  always_comb begin
    state_d    = state;
    prog_len_d = prog_len;
    depth_d    = depth;
    err_d      = err;
    wr_en      = 1'b0;
    if (load_start) begin
      state_d    = ST_LOAD;
      prog_len_d = '0;
      depth_d    = '0;
      err_d      = 2'b00;
    end else if (state == ST_LOAD && accept) begin
      if (in_data == CH_TERM) begin
        if (depth == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_ERR;
          err_d[1] = 1'b1;
        end
      end else if (is_cmd) begin
        if (prog_len == DEPTH_L) begin
          state_d  = ST_ERR;
          err_d[0] = 1'b1;
        end else if (opcode == OP_OPEN && depth == NEST_MAX) begin
          state_d  = ST_ERR;
          err_d[0] = 1'b1;
        end else if (opcode == OP_CLOSE && depth == '0) begin
          state_d  = ST_ERR;
          err_d[1] = 1'b1;
        end else begin
          wr_en      = 1'b1;
          prog_len_d = prog_len + (ADDR_W+1)'(1);
          if (opcode == OP_OPEN) begin
            depth_d = depth + NEST_W'(1);
          end else if (opcode == OP_CLOSE) begin
            depth_d = depth - NEST_W'(1);
          end
        end
      end
    end
  end

  // Control state with asynchronous reset to IDLE and an empty program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      prog_len <= '0;
      depth    <= '0;
      err      <= 2'b00;
    end else begin
      state    <= state_d;
      prog_len <= prog_len_d;
      depth    <= depth_d;
      err      <= err_d;
    end
  end

  // Opcode write at the current end of program.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[prog_len[ADDR_W-1:0]] <= opcode;
    end
  end

  // Fetch only from a completed, balanced program; everything else reads as a halting overrun.
  assign rd_hit      = (state == ST_DONE) && ({1'b0, addr} < prog_len);
  assign code        = rd_hit ? mem[addr] : 3'b111;
  assign rom_overrun = !rd_hit;

  assign busy = (state == ST_LOAD);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bf_program_loader.sv
// Purpose: directed bench for bf_program_loader: per-cycle vector table plus multi-cycle corner sequences.
// Latency: inputs are driven on the falling edge and outputs sampled 1 time unit later, before the rising edge.
// Backpressure: byte sends wait on in_ready with a bounded cycle budget.
module tb_bf_program_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [9:0]  addr;
  logic [2:0]  code;
  logic        rom_overrun;
  logic [10:0] prog_len;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  int n_checks = 0;
  int n_errors = 0;

  bf_program_loader #(.ADDR_W(10), .DEPTH(1024), .NEST_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .addr        (addr),
    .code        (code),
    .rom_overrun (rom_overrun),
    .prog_len    (prog_len),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output bundle: {in_ready, busy, done, err, prog_len, rom_overrun, code}
  typedef struct {
    logic        ls;
    logic        v;
    logic [7:0]  d;
    logic [9:0]  a;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] pack(logic rdy, logic bsy, logic dn, logic [1:0] e,
                                       logic [10:0] len, logic ovr, logic [2:0] c);
    return {rdy, bsy, dn, e, len, ovr, c};
  endfunction

  function automatic vec_t mk(logic ls, logic v, logic [7:0] d, logic [9:0] a,
                              logic rdy, logic bsy, logic dn, logic [1:0] e,
                              logic [10:0] len, logic ovr, logic [2:0] c);
    vec_t r;
    r.ls  = ls;
    r.v   = v;
    r.d   = d;
    r.a   = a;
    r.exp = pack(rdy, bsy, dn, e, len, ovr, c);
    return r;
  endfunction

  function automatic logic [19:0] observed();
    return pack(in_ready, busy, done, err, prog_len, rom_overrun, code);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    in_valid   = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input string name);
    int t;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: in_ready timeout, got 0 required 1", name);
    end
    @(posedge clk);
  endtask

  task automatic idle_check(input string name, input logic [9:0] a, input logic [19:0] req);
    @(negedge clk);
    in_valid = 1'b0;
    addr     = a;
    #1;
    chk(name, 32'(observed()), 32'(req));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] src[$];

    rst_n      = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    addr       = '0;

    // "+[-].!" streamed, then readback
    vecs.push_back(mk(0,0,8'h00,0,  0,0,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(1,1,8'h2B,0,  0,0,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(0,1,8'h2B,0,  1,1,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(0,1,8'h5B,0,  1,1,0,2'b00,1,1,3'b111));
    vecs.push_back(mk(0,1,8'h2D,0,  1,1,0,2'b00,2,1,3'b111));
    vecs.push_back(mk(0,1,8'h5D,0,  1,1,0,2'b00,3,1,3'b111));
    vecs.push_back(mk(0,1,8'h2E,0,  1,1,0,2'b00,4,1,3'b111));
    vecs.push_back(mk(0,1,8'h21,0,  1,1,0,2'b00,5,1,3'b111));
    vecs.push_back(mk(0,0,8'h00,0,  0,0,1,2'b00,5,0,3'b111));
    vecs.push_back(mk(0,0,8'h00,1,  0,0,1,2'b00,5,0,3'b011));
    vecs.push_back(mk(0,0,8'h00,2,  0,0,1,2'b00,5,0,3'b110));
    vecs.push_back(mk(0,0,8'h00,3,  0,0,1,2'b00,5,0,3'b010));
    vecs.push_back(mk(0,0,8'h00,4,  0,0,1,2'b00,5,0,3'b001));
    vecs.push_back(mk(0,0,8'h00,5,  0,0,1,2'b00,5,1,3'b111));
    // "]" -> unbalanced error, later bytes ignored
    vecs.push_back(mk(1,0,8'h00,0,  0,0,1,2'b00,5,0,3'b111));
    vecs.push_back(mk(0,1,8'h5D,0,  1,1,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(0,1,8'h2B,0,  0,0,0,2'b10,0,1,3'b111));
    vecs.push_back(mk(0,0,8'h00,0,  0,0,0,2'b10,0,1,3'b111));
    // reload "+!" clears the error
    vecs.push_back(mk(1,1,8'h2B,0,  0,0,0,2'b10,0,1,3'b111));
    vecs.push_back(mk(0,1,8'h2B,0,  1,1,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(0,1,8'h21,0,  1,1,0,2'b00,1,1,3'b111));
    vecs.push_back(mk(0,0,8'h00,0,  0,0,1,2'b00,1,0,3'b111));
    vecs.push_back(mk(0,0,8'h00,1,  0,0,1,2'b00,1,1,3'b111));
    // "[[+]!" -> unbalanced at terminator
    vecs.push_back(mk(1,0,8'h00,0,  0,0,1,2'b00,1,0,3'b111));
    vecs.push_back(mk(0,1,8'h5B,0,  1,1,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(0,1,8'h5B,0,  1,1,0,2'b00,1,1,3'b111));
    vecs.push_back(mk(0,1,8'h2B,0,  1,1,0,2'b00,2,1,3'b111));
    vecs.push_back(mk(0,1,8'h5D,0,  1,1,0,2'b00,3,1,3'b111));
    vecs.push_back(mk(0,1,8'h21,0,  1,1,0,2'b00,4,1,3'b111));
    vecs.push_back(mk(0,0,8'h00,0,  0,0,0,2'b10,4,1,3'b111));
    vecs.push_back(mk(0,0,8'h00,3,  0,0,0,2'b10,4,1,3'b111));
    // restart mid-load with a byte offered in the same cycle
    vecs.push_back(mk(1,0,8'h00,0,  0,0,0,2'b10,4,1,3'b111));
    vecs.push_back(mk(0,1,8'h2B,0,  1,1,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(0,1,8'h2D,0,  1,1,0,2'b00,1,1,3'b111));
    vecs.push_back(mk(1,1,8'h2B,0,  0,1,0,2'b00,2,1,3'b111));
    vecs.push_back(mk(0,0,8'h00,0,  1,1,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(0,1,8'h21,0,  1,1,0,2'b00,0,1,3'b111));
    vecs.push_back(mk(0,0,8'h00,0,  0,0,1,2'b00,0,1,3'b111));

    // Reset state while reset is held
    @(negedge clk);
    #1;
    chk("reset_held", 32'(observed()), 32'(pack(0,0,0,2'b00,0,1,3'b111)));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      load_start = vecs[i].ls;
      in_valid   = vecs[i].v;
      in_data    = vecs[i].d;
      addr       = vecs[i].a;
      #1;
      chk($sformatf("vec%0d", i), 32'(observed()), 32'(vecs[i].exp));
    end
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'b0;

    // "a+ b\n-!" with random valid gaps
    src = '{8'h61, 8'h2B, 8'h20, 8'h62, 8'h0A, 8'h2D, 8'h21};
    pulse_start();
    foreach (src[i]) send_byte(src[i], $urandom_range(0, 2), "gap_send");
    idle_check("gap_addr0", 0, pack(0,0,1,2'b00,2,0,3'b111));
    idle_check("gap_addr1", 1, pack(0,0,1,2'b00,2,0,3'b110));
    idle_check("gap_addr2", 2, pack(0,0,1,2'b00,2,1,3'b111));

    // Capacity: 1024 '+' fit, the 1025th overflows
    pulse_start();
    for (int i = 0; i < 1024; i++) send_byte(8'h2B, 0, "cap_send");
    idle_check("cap_full", 0, pack(1,1,0,2'b00,1024,1,3'b111));
    send_byte(8'h2B, 0, "cap_over_send");
    idle_check("cap_over", 0, pack(0,0,0,2'b01,1024,1,3'b111));
    idle_check("cap_over_addr", 1023, pack(0,0,0,2'b01,1024,1,3'b111));

    // Asynchronous reset after 3 accepted bytes
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'h3E, 0, "rst_send");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h2B;
    addr     = '0;
    #1;
    chk("rst_pre", 32'(observed()), 32'(pack(1,1,0,2'b00,3,1,3'b111)));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(observed()), 32'(pack(0,0,0,2'b00,0,1,3'b111)));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle_check("rst_after", 0, pack(0,0,0,2'b00,0,1,3'b111));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
